// File: rtl/neuromorphic_wb_pkg.sv
// Shared types and constants for the ReRAM Wishbone block initiator.
// Optional ack timeout is enabled with the WB_MASTER_TIMEOUT_EN macro.
package neuromorphic_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_HOLD     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic       OP_WRITE    = 1'b0;
  localparam logic       OP_READ     = 1'b1;
  localparam int         WORD_STRIDE = 4;
  localparam logic [3:0] SEL_ALL     = 4'hF;

  // The beat counter must hold MAX_BEATS itself, not just MAX_BEATS-1.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/neuromorphic_wb_master_if.sv
// Wishbone classic bus between the block initiator and the ReRAM slave.
interface neuromorphic_wb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_ack_watchdog.sv
// Counts consecutive cycles spent waiting for ack; flags expiry on the
// TIMEOUT_CYC-th cycle. Only built when WB_MASTER_TIMEOUT_EN is defined.
module wb_ack_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] count;

  // Disarming clears the count so every bus cycle gets a full budget.
  always_ff @(posedge clk) begin
    if (rst || !arm) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + TW'(1);
    end
  end

  assign expired = arm && (count == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/neuromorphic_wb_master.sv
// Block-command Wishbone classic initiator: one single cycle per word at
// consecutive addresses. Define WB_MASTER_TIMEOUT_EN for the ack timeout abort.
module neuromorphic_wb_master
  import neuromorphic_wb_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int MAX_BEATS   = 32,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int CW          = cnt_width(MAX_BEATS)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [CW-1:0]            cmd_cnt,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     rdata_valid,
  input  logic                     rdata_ready,
  output logic [DATA_W-1:0]        rdata,
  neuromorphic_wb_master_if.master wb,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  if (MAX_BEATS < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("neuromorphic_wb_master: MAX_BEATS must be >= 1 and TIMEOUT_CYC >= 2");
  end

  state_e              state, state_nxt;
  logic                op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CW-1:0]       remain_q;
  logic [DATA_W-1:0]   wdat_q;
  logic [DATA_W-1:0]   rdat_q;
  logic                cyc;
  logic                beat_done;
  logic                last_beat;
  logic                ack_timeout;

  assign last_beat = (remain_q == CW'(1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves one unassigned and a latch is never inferred.
  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    cyc         = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    beat_done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_cnt == '0)          state_nxt = ST_DONE;
          else if (cmd_op == OP_READ) state_nxt = ST_REQ;
          else                        state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        wdata_ready = 1'b1;
        if (wdata_valid) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        cyc       = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        cyc = 1'b1;
        // An ack arriving on the expiry cycle still completes the beat.
        if (wb.wbm_ack_i) begin
          if (op_q == OP_READ) begin
            state_nxt = ST_HOLD;
          end else begin
            beat_done = 1'b1;
            state_nxt = last_beat ? ST_DONE : ST_FETCH;
          end
        end else if (ack_timeout) begin
          state_nxt = ST_DONE;
        end
      end
      ST_HOLD: begin
        rdata_valid = 1'b1;
        if (rdata_ready) begin
          beat_done = 1'b1;
          state_nxt = last_beat ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because they drive outputs that
  // must read as zero out of reset (address, write data, read data).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      op_q     <= OP_WRITE;
      addr_q   <= '0;
      remain_q <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        op_q     <= cmd_op;
        addr_q   <= cmd_addr;
        remain_q <= cmd_cnt;
      end
      if (wdata_valid && wdata_ready) wdat_q <= wdata;
      if (state == ST_WAIT_ACK && wb.wbm_ack_i && op_q == OP_READ) rdat_q <= wb.wbm_dat_i;
      // Address wraps modulo 2^ADDR_W by plain truncation.
      if (beat_done) begin
        addr_q   <= addr_q + ADDR_W'(WORD_STRIDE);
        remain_q <= remain_q - CW'(1);
      end
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  logic err_q;

  wb_ack_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ack_watchdog (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .arm     (state == ST_WAIT_ACK),
    .expired (ack_timeout)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      err_q <= 1'b0;
    end else if (state == ST_WAIT_ACK && !wb.wbm_ack_i && ack_timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = done & err_q;
`else
  assign ack_timeout = 1'b0;
  assign err         = 1'b0;
`endif

  assign wb.wbm_cyc_o = cyc;
  assign wb.wbm_stb_o = cyc;
  assign wb.wbm_we_o  = cyc & (op_q ^ 1'b1);
  assign wb.wbm_sel_o = SEL_ALL;
  assign wb.wbm_adr_o = addr_q;
  assign wb.wbm_dat_o = wdat_q;
  assign rdata        = rdat_q;

endmodule
